// File: rtl/hwpe_stream_strb_packer_pkg.sv
// Shared types for the strobe packer: control word and FSM state encoding.
package hwpe_stream_strb_packer_pkg;

  typedef struct packed {
    logic [31:0] trans_size;
  } ctrl_strbpack_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } strbpack_state_t;

endpackage

// File: rtl/hwpe_stream_strb_packer_if.sv
// HWPE-Stream handshake bundle: valid/ready with byte-strobed data.
interface hwpe_stream_strb_packer_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                      valid;
  logic                      ready;
  logic [DATA_WIDTH-1:0]     data;
  logic [DATA_WIDTH/8-1:0]   strb;

  modport master (
    output valid, data, strb,
    input  ready
  );

  modport slave (
    input  valid, data, strb,
    output ready
  );

endinterface

// File: rtl/hwpe_stream_strb_prefix_cnt.sv
// Leading-ones count of a byte strobe, plus a flag telling whether the
// strobe is a contiguous low-aligned mask (2^k-1).
module hwpe_stream_strb_prefix_cnt #(
  parameter int unsigned NB = 4,
  localparam int unsigned CW = $clog2(NB) + 1,
  localparam int unsigned BW = $clog2(NB)
) (
  input  logic [NB-1:0] i_strb,
  output logic [CW-1:0] o_cnt,
  output logic          o_contig
);

  logic w_run;

  // Count ones from bit 0 until the first zero; any later one breaks contiguity.
  always_comb begin
    o_cnt    = '0;
    o_contig = 1'b1;
    w_run    = 1'b1;
    for (int unsigned i = 0; i < NB; i++) begin
      if (i_strb[BW'(i)]) begin
        if (w_run) o_cnt = o_cnt + CW'(1);
        else       o_contig = 1'b0;
      end else begin
        w_run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/hwpe_stream_strb_packer.sv
// Strobe packer: compacts low-aligned partial words into dense words and
// flushes the residue as one low-aligned partial word at end of transfer.
// Optional strobe contiguity check: define HWPE_STREAM_STRB_PACKER_CHECK_EN.
module hwpe_stream_strb_packer
  import hwpe_stream_strb_packer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      test_mode_i,
  input  logic                      clear_i,
  input  logic                      start_i,
  input  ctrl_strbpack_t            ctrl_i,
  output logic                      done_o,
  output logic                      err_o,
  hwpe_stream_strb_packer_if.slave  push_i,
  hwpe_stream_strb_packer_if.master pop_o
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned FW = $clog2(2 * NB) + 1;
  localparam int unsigned CW = $clog2(NB) + 1;
  localparam int unsigned AW = $clog2(2 * NB);
  localparam int unsigned BW = $clog2(NB);

  strbpack_state_t r_state, w_state_next;
  logic [FW-1:0]          r_fill, w_fill_next, w_out_bytes, w_base;
  logic [2*NB-1:0][7:0]   r_acc, w_acc_next;
  logic [31:0]            r_cnt, w_cnt_next, r_size;
  logic [CW-1:0]          w_k;
  logic                   w_contig;
  logic                   w_push_ready, w_pop_valid, w_in_hs, w_out_hs, w_done;
  logic [NB-1:0][7:0]     w_push_bytes, w_pop_bytes;
  logic [NB-1:0]          w_pop_strb;

  hwpe_stream_strb_prefix_cnt #(
    .NB (NB)
  ) i_prefix_cnt (
    .i_strb   (push_i.strb),
    .o_cnt    (w_k),
    .o_contig (w_contig)
  );

  assign w_push_bytes = push_i.data;

  assign w_push_ready = (r_state == RUN) & ((r_fill < FW'(NB)) | pop_o.ready);
  assign w_pop_valid  = ((r_state == RUN)   & (r_fill >= FW'(NB))) |
                        ((r_state == FLUSH) & (r_fill != '0));
  assign w_in_hs      = push_i.valid & w_push_ready;
  assign w_out_hs     = w_pop_valid & pop_o.ready;

  assign push_i.ready = w_push_ready;
  assign pop_o.valid  = w_pop_valid;
  assign pop_o.data   = w_pop_bytes;
  assign pop_o.strb   = w_pop_strb;
  assign done_o       = w_done;

  // Output word: low NB accumulator bytes, bytes at or above fill masked to zero.
  always_comb begin
    w_pop_bytes = '0;
    w_pop_strb  = '0;
    for (int unsigned j = 0; j < NB; j++) begin
      if (32'(r_fill) > j) begin
        w_pop_bytes[BW'(j)] = r_acc[AW'(j)];
        w_pop_strb[BW'(j)]  = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i | clear_i) r_state <= IDLE;
    else                 r_state <= w_state_next;
  end

  // FSM next state, word counting and done pulse.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_done       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          w_cnt_next   = '0;
          w_state_next = (ctrl_i.trans_size == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_in_hs) begin
          w_cnt_next = r_cnt + 32'd1;
          if (r_cnt == r_size - 32'd1) w_state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (r_fill == '0) w_state_next = DONE;
      end
      DONE: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
    endcase
  end

  // Accumulator update: shift out the emitted word, then append at the post-shift fill.
  always_comb begin
    w_out_bytes = (r_fill >= FW'(NB)) ? FW'(NB) : r_fill;
    w_base      = w_out_hs ? (r_fill - w_out_bytes) : r_fill;
    w_fill_next = w_base + (w_in_hs ? FW'(w_k) : '0);
    w_acc_next  = r_acc;
    if (w_out_hs) begin
      for (int unsigned j = 0; j < 2 * NB; j++) begin
        if (j < NB) w_acc_next[AW'(j)] = r_acc[AW'(j + NB)];
        else        w_acc_next[AW'(j)] = '0;
      end
    end
    if (w_in_hs) begin
      for (int unsigned j = 0; j < 2 * NB; j++) begin
        if ((j >= 32'(w_base)) && ((j - 32'(w_base)) < 32'(w_k)))
          w_acc_next[AW'(j)] = w_push_bytes[BW'(j - 32'(w_base))];
      end
    end
  end

  // Datapath registers: accumulator, fill level, word count, latched size.
  always_ff @(posedge clk_i) begin
    if (rst_i | clear_i) begin
      r_acc  <= '0;
      r_fill <= '0;
      r_cnt  <= '0;
      r_size <= '0;
    end else begin
      r_acc  <= w_acc_next;
      r_fill <= w_fill_next;
      r_cnt  <= w_cnt_next;
      if ((r_state == IDLE) && start_i) r_size <= ctrl_i.trans_size;
    end
  end

`ifdef HWPE_STREAM_STRB_PACKER_CHECK_EN
  logic r_err;
  logic w_unused;
  assign w_unused = test_mode_i;

  // Sticky flag for accepted words whose strobe is not a low-aligned mask.
  always_ff @(posedge clk_i) begin
    if (rst_i | clear_i)                r_err <= 1'b0;
    else if ((r_state == IDLE) && start_i) r_err <= 1'b0;
    else if (w_in_hs && !w_contig)      r_err <= 1'b1;
  end

  assign err_o = r_err;

  a_strb_contig: assert property (@(posedge clk_i) disable iff (rst_i || clear_i)
    (w_in_hs && !w_contig) |=> err_o);
`else
  logic w_unused;
  assign w_unused = ^{test_mode_i, w_contig};
  assign err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_hwpe_stream_strb_packer.sv
// Scoreboard bench for hwpe_stream_strb_packer (DATA_WIDTH=32).
module tb_hwpe_stream_strb_packer;
  import hwpe_stream_strb_packer_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;

  logic           clk;
  logic           rst, test_mode, clear, start;
  ctrl_strbpack_t ctrl;
  logic           done, err;

  hwpe_stream_strb_packer_if #(.DATA_WIDTH(32)) push_if ();
  hwpe_stream_strb_packer_if #(.DATA_WIDTH(32)) pop_if ();

  hwpe_stream_strb_packer #(.DATA_WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .test_mode_i (test_mode),
    .clear_i     (clear),
    .start_i     (start),
    .ctrl_i      (ctrl),
    .done_o      (done),
    .err_o       (err),
    .push_i      (push_if),
    .pop_o       (pop_if)
  );

  int    checks = 0;
  int    errors = 0;
  int    done_seen = 0;
  int    exp_done = 0;
  int    cycle = 0;
  int    ready_mode = 0;
  beat_t exp_q[$];
  int    out_cyc[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, expv, cycle);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cycle);
  endtask

  // Monitor: pops expected beats on every output handshake and checks stall stability.
  initial begin : monitor
    logic        stalled;
    logic [31:0] hd;
    logic [3:0]  hs;
    beat_t       e;
    stalled = 1'b0;
    hd = '0;
    hs = '0;
    forever begin
      @(negedge clk);
      if (rst || clear) begin
        stalled = 1'b0;
      end else begin
        if (done) done_seen++;
        if (stalled) begin
          check("stall_valid", 32'(pop_if.valid), 32'd1);
          check("stall_data", pop_if.data, hd);
          check("stall_strb", 32'(pop_if.strb), 32'(hs));
        end
        if (pop_if.valid && pop_if.ready) begin
          stalled = 1'b0;
          out_cyc.push_back(cycle);
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_output: data=0x%0h strb=0x%0h", pop_if.data, pop_if.strb);
            checks++;
            errors++;
          end else begin
            e = exp_q.pop_front();
            check("out_data", pop_if.data, e.data);
            check("out_strb", 32'(pop_if.strb), 32'(e.strb));
          end
        end else if (pop_if.valid) begin
          stalled = 1'b1;
          hd = pop_if.data;
          hs = pop_if.strb;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  // Output backpressure: 0 = always ready, 1 = toggling, 2 = never ready.
  initial begin : ready_drv
    pop_if.ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0)      pop_if.ready = 1'b1;
      else if (ready_mode == 1) pop_if.ready = ~pop_if.ready;
      else                      pop_if.ready = 1'b0;
    end
  end

  task automatic do_start(input logic [31:0] n);
    @(posedge clk);
    #1;
    ctrl.trans_size = n;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic push_words(input beat_t ins[$]);
    int t;
    for (int i = 0; i < ins.size(); i++) begin
      push_if.valid = 1'b1;
      push_if.data  = ins[i].data;
      push_if.strb  = ins[i].strb;
      t = 0;
      while (1) begin
        @(negedge clk);
        if (push_if.ready) break;
        t++;
        if (t > 200) break;
      end
      if (t > 200) begin
        fail("push_timeout");
        push_if.valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    push_if.valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (done_seen < exp_done && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (done_seen < exp_done) fail({name, "_done_timeout"});
    repeat (3) @(negedge clk);
    #1;
    check({name, "_done_count"}, 32'(done_seen), 32'(exp_done));
    check({name, "_pending_outputs"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    done_seen = exp_done;
  endtask

  task automatic run_xfer(input string name, input logic [31:0] n,
                          input beat_t ins[$], input beat_t outs[$]);
    foreach (outs[i]) exp_q.push_back(outs[i]);
    exp_done++;
    do_start(n);
    push_words(ins);
    wait_done(name);
  endtask

  initial begin : main
    beat_t none[$];
    none = {};
    rst = 1'b1;
    test_mode = 1'b0;
    clear = 1'b0;
    start = 1'b0;
    ctrl = '0;
    push_if.valid = 1'b0;
    push_if.data  = '0;
    push_if.strb  = '0;
    ready_mode = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pop_valid", 32'(pop_if.valid), 32'd0);
    check("rst_push_ready", 32'(push_if.ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Dense pass-through at one word per cycle.
    ready_mode = 0;
    out_cyc.delete();
    run_xfer("dense", 32'd4,
      '{'{32'h03020100, 4'hF}, '{32'h07060504, 4'hF}, '{32'h0B0A0908, 4'hF}, '{32'h0F0E0D0C, 4'hF}},
      '{'{32'h03020100, 4'hF}, '{32'h07060504, 4'hF}, '{32'h0B0A0908, 4'hF}, '{32'h0F0E0D0C, 4'hF}});
    if (out_cyc.size() == 4) check("dense_throughput", 32'(out_cyc[3] - out_cyc[0]), 32'd3);
    else fail("dense_output_count");

    // Line-end merge with a flushed partial word.
    run_xfer("merge", 32'd3,
      '{'{32'h44332211, 4'hF}, '{32'h00006655, 4'h3}, '{32'hAA998877, 4'hF}},
      '{'{32'h44332211, 4'hF}, '{32'h88776655, 4'hF}, '{32'h0000AA99, 4'h3}});

    // Same under toggling backpressure.
    ready_mode = 1;
    run_xfer("merge_bp", 32'd3,
      '{'{32'h44332211, 4'hF}, '{32'h00006655, 4'h3}, '{32'hAA998877, 4'hF}},
      '{'{32'h44332211, 4'hF}, '{32'h88776655, 4'hF}, '{32'h0000AA99, 4'h3}});

    // Bytes above the strobe are dropped; accumulator reaches 7 bytes.
    run_xfer("drop_bp", 32'd3,
      '{'{32'hEE030201, 4'h7}, '{32'h07060504, 4'hF}, '{32'hFFFFFF08, 4'h1}},
      '{'{32'h04030201, 4'hF}, '{32'h08070605, 4'hF}});
    ready_mode = 0;

    // Zero-length transfer: done one cycle after start.
    exp_done++;
    do_start(32'd0);
    @(negedge clk);
    check("zero_done_first", 32'(done), 32'd1);
    @(negedge clk);
    check("zero_done_second", 32'(done), 32'd0);
    wait_done("zero");

    // Empty strobes: words counted, nothing emitted.
    run_xfer("empty_strb", 32'd2, '{'{32'h12345678, 4'h0}, '{32'h9ABCDEF0, 4'h0}}, none);

    // Clear mid-transfer with two bytes buffered.
    do_start(32'd3);
    push_words('{'{32'h0000BBAA, 4'h3}});
    @(negedge clk);
    check("clear_pre_ready", 32'(push_if.ready), 32'd1);
    @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    check("clear_pop_valid", 32'(pop_if.valid), 32'd0);
    check("clear_push_ready", 32'(push_if.ready), 32'd0);
    repeat (5) @(negedge clk);
    #1;
    check("clear_no_done", 32'(done_seen), 32'(exp_done));

    // Restart after clear; partial word bytes above fill read as zero.
    run_xfer("restart", 32'd2,
      '{'{32'hDDCCBBAA, 4'hF}, '{32'h55555511, 4'h1}},
      '{'{32'hDDCCBBAA, 4'hF}, '{32'h00000011, 4'h1}});

`ifdef HWPE_STREAM_STRB_PACKER_CHECK_EN
    exp_q.push_back('{32'h00000011, 4'h1});
    exp_done++;
    do_start(32'd1);
    push_words('{'{32'h44332211, 4'h5}});
    @(negedge clk);
    check("chk_err_set", 32'(err), 32'd1);
    wait_done("chk");
    check("chk_err_sticky", 32'(err), 32'd1);
    run_xfer("chk_clean", 32'd1, '{'{32'h87654321, 4'hF}}, '{'{32'h87654321, 4'hF}});
    check("chk_err_cleared", 32'(err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
